// File: rtl/xgmii_pkg.sv
// Shared XGMII / 64b66b definitions: characters, 7-bit control codes, block types,
// receive frame states and the control-code lookup used by the decoder and encoder.
package xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_LPI   = 8'h06;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  localparam logic [7:0] XGMII_RES0  = 8'h1C;
  localparam logic [7:0] XGMII_RES1  = 8'h3C;
  localparam logic [7:0] XGMII_RES2  = 8'h7C;
  localparam logic [7:0] XGMII_RES3  = 8'hBC;
  localparam logic [7:0] XGMII_RES4  = 8'hDC;
  localparam logic [7:0] XGMII_RES5  = 8'hF7;

  localparam logic [6:0] CC_IDLE  = 7'h00;
  localparam logic [6:0] CC_LPI   = 7'h06;
  localparam logic [6:0] CC_ERROR = 7'h1E;
  localparam logic [6:0] CC_RES0  = 7'h2D;
  localparam logic [6:0] CC_RES1  = 7'h33;
  localparam logic [6:0] CC_RES2  = 7'h4B;
  localparam logic [6:0] CC_RES3  = 7'h55;
  localparam logic [6:0] CC_RES4  = 7'h66;
  localparam logic [6:0] CC_RES5  = 7'h78;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] BT_CTRL   = 8'h1E;
  localparam logic [7:0] BT_START0 = 8'h78;
  localparam logic [7:0] BT_START4 = 8'h33;
  localparam logic [7:0] BT_TERM0  = 8'h87;
  localparam logic [7:0] BT_TERM1  = 8'h99;
  localparam logic [7:0] BT_TERM2  = 8'hAA;
  localparam logic [7:0] BT_TERM3  = 8'hB4;
  localparam logic [7:0] BT_TERM4  = 8'hCC;
  localparam logic [7:0] BT_TERM5  = 8'hD2;
  localparam logic [7:0] BT_TERM6  = 8'hE1;
  localparam logic [7:0] BT_TERM7  = 8'hFF;

  typedef enum logic {RX_C, RX_D} rx_state_e;

  typedef enum logic [2:0] {K_DATA, K_CTRL, K_START, K_TERM, K_BAD} blk_kind_e;

  typedef struct packed {
    logic       err;
    logic [7:0] chr;
  } ctrl_dec_t;

  function automatic ctrl_dec_t ctrl_lookup(input logic [6:0] code);
    ctrl_dec_t r;
    r.err = 1'b0;
    case (code)
      CC_IDLE:  r.chr = XGMII_IDLE;
      CC_LPI:   r.chr = XGMII_LPI;
      CC_ERROR: r.chr = XGMII_ERROR;
      CC_RES0:  r.chr = XGMII_RES0;
      CC_RES1:  r.chr = XGMII_RES1;
      CC_RES2:  r.chr = XGMII_RES2;
      CC_RES3:  r.chr = XGMII_RES3;
      CC_RES4:  r.chr = XGMII_RES4;
      CC_RES5:  r.chr = XGMII_RES5;
      default: begin
        r.chr = XGMII_ERROR;
        r.err = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/xgmii_decoder.sv
// 64b/66b block decoder fed one half-block per valid word; emits lanes 0-3 then
// lanes 4-7 on consecutive cycles, replacing malformed or out-of-sequence blocks.
module xgmii_decoder
  import xgmii_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = DATA_WIDTH/8,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_encoded_data,
  input  logic                  i_encoded_data_valid,
  input  logic [HDR_WIDTH-1:0]  i_sync_hdr,
  output logic [DATA_WIDTH-1:0] o_xgmii_rxd,
  output logic [CTRL_WIDTH-1:0] o_xgmii_rxc,
  output logic                  o_xgmii_valid,
  output logic                  o_decoding_err
);

  localparam int BLK_W = 2*DATA_WIDTH;
  localparam int LANES = BLK_W/8;

  logic                  half_reg;
  logic [DATA_WIDTH-1:0] first_reg;
  logic [HDR_WIDTH-1:0]  sync_reg;
  rx_state_e             state_reg, state_next;

  logic                  accept_second;
  logic [BLK_W-1:0]      block, data_shift, dec_d;
  logic [LANES-1:0]      dec_c, code_bad;
  logic [7:0]            code_chr [LANES];
  blk_kind_e             kind;
  logic [3:0]            term_n;
  logic                  blk_err;

  logic [DATA_WIDTH-1:0] hi_d_reg;
  logic [CTRL_WIDTH-1:0] hi_c_reg;
  logic                  hi_err_reg, hi_pend_reg;

  assign accept_second = i_encoded_data_valid && half_reg;
  assign block         = {i_encoded_data, first_reg};
  assign data_shift    = block >> 8;

  // Every possible 7-bit control code slot is looked up in parallel.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_cc
      ctrl_dec_t cd;
      assign cd           = ctrl_lookup(block[8+7*gi +: 7]);
      assign code_chr[gi] = cd.chr;
      assign code_bad[gi] = cd.err;
    end
  endgenerate

  always_comb begin
    kind       = K_BAD;
    dec_d      = '0;
    dec_c      = '0;
    term_n     = '0;
    blk_err    = 1'b0;
    state_next = state_reg;
    if (sync_reg == SYNC_DATA) begin
      kind  = K_DATA;
      dec_d = block;
    end else if (sync_reg == SYNC_CTRL) begin
      case (block[7:0])
        BT_CTRL: begin
          kind  = (|code_bad) ? K_BAD : K_CTRL;
          dec_c = '1;
          for (int i = 0; i < LANES; i++) dec_d[8*i +: 8] = code_chr[i];
        end
        BT_START0: begin
          kind  = K_START;
          dec_d = {block[BLK_W-1:8], XGMII_START};
          dec_c = LANES'(1);
        end
        BT_START4: begin
          kind = (|code_bad[3:0]) ? K_BAD : K_START;
          for (int i = 0; i < 4; i++) dec_d[8*i +: 8] = code_chr[i];
          dec_d[39:32]      = XGMII_START;
          dec_d[BLK_W-1:40] = block[BLK_W-1:40];
          dec_c             = LANES'(8'h1F);
        end
        BT_TERM0: begin kind = K_TERM; term_n = 4'd0; end
        BT_TERM1: begin kind = K_TERM; term_n = 4'd1; end
        BT_TERM2: begin kind = K_TERM; term_n = 4'd2; end
        BT_TERM3: begin kind = K_TERM; term_n = 4'd3; end
        BT_TERM4: begin kind = K_TERM; term_n = 4'd4; end
        BT_TERM5: begin kind = K_TERM; term_n = 4'd5; end
        BT_TERM6: begin kind = K_TERM; term_n = 4'd6; end
        BT_TERM7: begin kind = K_TERM; term_n = 4'd7; end
        default: ;
      endcase
      if (kind == K_TERM) begin
        for (int i = 0; i < LANES; i++) begin
          if (4'(i) < term_n) begin
            dec_d[8*i +: 8] = data_shift[8*i +: 8];
          end else if (4'(i) == term_n) begin
            dec_d[8*i +: 8] = XGMII_TERM;
            dec_c[i]        = 1'b1;
          end else begin
            dec_d[8*i +: 8] = XGMII_IDLE;
            dec_c[i]        = 1'b1;
          end
        end
      end
    end

    // Frame sequencing: a start inside a frame is flagged but keeps the frame open.
    case (state_reg)
      RX_C: begin
        case (kind)
          K_START: state_next = RX_D;
          K_CTRL:  ;
          default: blk_err = 1'b1;
        endcase
      end
      RX_D: begin
        case (kind)
          K_DATA:  ;
          K_TERM:  state_next = RX_C;
          K_START: blk_err = 1'b1;
          default: begin
            blk_err    = 1'b1;
            state_next = RX_C;
          end
        endcase
      end
      default: state_next = RX_C;
    endcase

    if (blk_err) begin
      dec_d = {LANES{XGMII_ERROR}};
      dec_c = '1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state_reg <= RX_C;
    else if (accept_second) state_reg <= state_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      half_reg       <= 1'b0;
      first_reg      <= '0;
      sync_reg       <= '0;
      hi_d_reg       <= '0;
      hi_c_reg       <= '0;
      hi_err_reg     <= 1'b0;
      hi_pend_reg    <= 1'b0;
      o_xgmii_rxd    <= '0;
      o_xgmii_rxc    <= '0;
      o_xgmii_valid  <= 1'b0;
      o_decoding_err <= 1'b0;
    end else begin
      if (i_encoded_data_valid) begin
        half_reg <= ~half_reg;
        if (!half_reg) begin
          first_reg <= i_encoded_data;
          sync_reg  <= i_sync_hdr;
        end
      end
      // A new block can complete at most every other cycle, so the upper
      // lanes always drain before the next lower lanes arrive.
      if (accept_second) begin
        o_xgmii_rxd    <= dec_d[DATA_WIDTH-1:0];
        o_xgmii_rxc    <= dec_c[CTRL_WIDTH-1:0];
        o_xgmii_valid  <= 1'b1;
        o_decoding_err <= blk_err;
        hi_d_reg       <= dec_d[BLK_W-1:DATA_WIDTH];
        hi_c_reg       <= dec_c[LANES-1:CTRL_WIDTH];
        hi_err_reg     <= blk_err;
        hi_pend_reg    <= 1'b1;
      end else if (hi_pend_reg) begin
        o_xgmii_rxd    <= hi_d_reg;
        o_xgmii_rxc    <= hi_c_reg;
        o_xgmii_valid  <= 1'b1;
        o_decoding_err <= hi_err_reg;
        hi_pend_reg    <= 1'b0;
      end else begin
        o_xgmii_rxd    <= '0;
        o_xgmii_rxc    <= '0;
        o_xgmii_valid  <= 1'b0;
        o_decoding_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xgmii_decoder.sv
// Directed bench for xgmii_decoder: a block-level reference model fills a timed
// expectation queue that is compared against the outputs on every cycle.
module tb_xgmii_decoder;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic [31:0] i_encoded_data;
  logic        i_encoded_data_valid;
  logic [1:0]  i_sync_hdr;
  logic [31:0] o_xgmii_rxd;
  logic [3:0]  o_xgmii_rxc;
  logic        o_xgmii_valid;
  logic        o_decoding_err;

  always #5 clk = ~clk;

  xgmii_decoder dut (
    .i_clk                (clk),
    .i_reset_n            (i_reset_n),
    .i_encoded_data       (i_encoded_data),
    .i_encoded_data_valid (i_encoded_data_valid),
    .i_sync_hdr           (i_sync_hdr),
    .o_xgmii_rxd          (o_xgmii_rxd),
    .o_xgmii_rxc          (o_xgmii_rxc),
    .o_xgmii_valid        (o_xgmii_valid),
    .o_decoding_err       (o_decoding_err)
  );

  typedef struct {
    int          due;
    logic [31:0] d;
    logic [3:0]  c;
    logic        e;
  } exp_t;

  exp_t expq[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   in_frame = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  function automatic logic [7:0] cc(input logic [6:0] code, output bit ok);
    logic [6:0] codes [9] = '{7'h00, 7'h06, 7'h1E, 7'h2D, 7'h33, 7'h4B, 7'h55, 7'h66, 7'h78};
    logic [7:0] chars [9] = '{8'h07, 8'h06, 8'hFE, 8'h1C, 8'h3C, 8'h7C, 8'hBC, 8'hDC, 8'hF7};
    logic [7:0] r = 8'hFE;
    ok = 0;
    for (int j = 0; j < 9; j++) if (codes[j] == code) begin r = chars[j]; ok = 1; end
    return r;
  endfunction

  function automatic int term_pos(input logic [7:0] t);
    logic [7:0] types [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    int r = -1;
    for (int j = 0; j < 8; j++) if (types[j] == t) r = j;
    return r;
  endfunction

  // kind: 0 data, 1 control, 2 start, 3 terminate, 4 malformed
  function automatic void model(input logic [1:0] s, input logic [63:0] b, inout bit fr,
                                output logic [63:0] d, output logic [7:0] c, output bit e);
    logic [7:0] lane [8];
    bit         ctl  [8];
    int         kind = 4;
    int         n;
    bit         ok;
    bit         err;
    for (int i = 0; i < 8; i++) begin lane[i] = 8'h00; ctl[i] = 0; end
    n = term_pos(b[7:0]);
    if (s == 2'b01) begin
      kind = 0;
      for (int i = 0; i < 8; i++) lane[i] = b[8*i +: 8];
    end else if (s == 2'b10) begin
      if (b[7:0] == 8'h1E) begin
        kind = 1;
        for (int i = 0; i < 8; i++) begin
          lane[i] = cc(b[8+7*i +: 7], ok); ctl[i] = 1;
          if (!ok) kind = 4;
        end
      end else if (b[7:0] == 8'h78) begin
        kind = 2; lane[0] = 8'hFB; ctl[0] = 1;
        for (int i = 1; i < 8; i++) lane[i] = b[8*i +: 8];
      end else if (b[7:0] == 8'h33) begin
        kind = 2;
        for (int i = 0; i < 4; i++) begin
          lane[i] = cc(b[8+7*i +: 7], ok); ctl[i] = 1;
          if (!ok) kind = 4;
        end
        lane[4] = 8'hFB; ctl[4] = 1;
        for (int i = 5; i < 8; i++) lane[i] = b[8*i +: 8];
      end else if (n >= 0) begin
        kind = 3;
        for (int i = 0; i < 8; i++) begin
          if (i < n) lane[i] = b[8+8*i +: 8];
          else begin lane[i] = (i == n) ? 8'hFD : 8'h07; ctl[i] = 1; end
        end
      end
    end
    err = (kind == 4);
    if (fr) begin
      if (kind == 3 || kind == 4) fr = 0;
      else if (kind == 1) begin err = 1; fr = 0; end
      else if (kind == 2) err = 1;
    end else begin
      if (kind == 2) fr = 1;
      else if (kind == 0 || kind == 3) err = 1;
    end
    for (int i = 0; i < 8; i++) begin
      d[8*i +: 8] = err ? 8'hFE : lane[i];
      c[i]        = err ? 1'b1 : ctl[i];
    end
    e = err;
  endfunction

  always @(negedge clk) begin
    if (expq.size() > 0 && expq[0].due == cyc) begin
      cur = expq.pop_front();
      $display("word cyc=%0d rxd=%h rxc=%h err=%b", cyc, o_xgmii_rxd, o_xgmii_rxc, o_decoding_err);
      check("out_valid", 64'(o_xgmii_valid), 64'd1);
      check("out_rxd", 64'(o_xgmii_rxd), 64'(cur.d));
      check("out_rxc", 64'(o_xgmii_rxc), 64'(cur.c));
      check("out_err", 64'(o_decoding_err), 64'(cur.e));
    end else begin
      check("idle_valid", 64'(o_xgmii_valid), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d);
    i_encoded_data_valid = v;
    i_sync_hdr           = s;
    i_encoded_data       = d;
    tick();
  endtask

  task automatic send_block(input logic [1:0] s, input logic [63:0] b, input int gap);
    logic [63:0] d;
    logic [7:0]  c;
    bit          e;
    drive(1'b1, s, b[31:0]);
    repeat (gap) drive(1'b0, 2'b11, 32'hDEADBEEF);
    model(s, b, in_frame, d, c, e);
    expq.push_back('{cyc + 1, d[31:0], c[3:0], e});
    expq.push_back('{cyc + 2, d[63:32], c[7:4], e});
    drive(1'b1, 2'b00, b[63:32]);
    i_encoded_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_encoded_data_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    i_reset_n            = 1'b0;
    i_encoded_data_valid = 1'b0;
    while (expq.size() > 0 && expq[expq.size()-1].due > cyc) void'(expq.pop_back());
    in_frame = 0;
    tick();
    i_reset_n = 1'b1;
  endtask

  localparam logic [63:0] IDLE_BLK = 64'h00000000_0000001E;
  localparam logic [63:0] START0   = 64'h77665544_33221178;
  localparam logic [63:0] DATA0    = 64'h07060504_03020100;
  localparam logic [63:0] TERM5    = 64'h0000EEDD_CCBBAAD2;
  localparam logic [63:0] CODES    = {7'h78, 7'h66, 7'h55, 7'h4B, 7'h33, 7'h2D, 7'h1E, 7'h06, 8'h1E};

  initial begin
    logic [63:0] pd;
    logic [7:0]  pc;
    bit          pe;
    bit          pf;

    pf = 0; model(2'b10, IDLE_BLK, pf, pd, pc, pe);
    check("pin_idle", {pd, pc, 7'd0, pe}, {64'h07070707_07070707, 8'hFF, 8'h00});
    pf = 1; model(2'b10, TERM5, pf, pd, pc, pe);
    check("pin_term5", {pd, pc, 7'd0, pe}, {64'h0707FDEE_DDCCBBAA, 8'hE0, 8'h00});
    pf = 0; model(2'b01, DATA0, pf, pd, pc, pe);
    check("pin_data_in_c", {pd, pc, 7'd0, pe}, {64'hFEFEFEFE_FEFEFEFE, 8'hFF, 8'h01});
    pf = 0; model(2'b10, CODES, pf, pd, pc, pe);
    check("pin_codes", {pd, pc, 7'd0, pe}, {64'hF7DCBC7C_3C1CFE06, 8'hFF, 8'h00});

    i_reset_n = 1'b0; i_encoded_data_valid = 1'b0; i_sync_hdr = 2'b00; i_encoded_data = '0;
    tick();
    tick();
    i_reset_n = 1'b1;
    check("reset_state", {o_xgmii_rxd, 3'd0, o_xgmii_valid, o_xgmii_rxc, 7'd0, o_decoding_err}, 48'd0);

    send_block(2'b10, IDLE_BLK, 0);
    idle(2);
    send_block(2'b10, START0, 0);
    send_block(2'b01, DATA0, 0);
    send_block(2'b10, TERM5, 0);
    idle(3);
    send_block(2'b10, START0, 0);
    send_block(2'b11, DATA0, 0);
    send_block(2'b01, DATA0, 0);
    idle(2);
    send_block(2'b01, DATA0, 0);
    send_block(2'b10, 64'hABCDEF00_00000033, 0);
    send_block(2'b10, 64'h00000000_00000087, 0);
    send_block(2'b10, CODES, 0);
    send_block(2'b10, 64'h00000000_00200000 | IDLE_BLK, 0);
    send_block(2'b10, 64'h00000000_0000004B, 0);
    send_block(2'b10, 64'h00000000_00000000, 0);
    idle(2);
    send_block(2'b10, START0, 0);
    send_block(2'b10, START0, 0);
    send_block(2'b01, DATA0, 0);
    send_block(2'b10, 64'h11223344_556677FF, 0);
    send_block(2'b10, START0, 0);
    send_block(2'b10, IDLE_BLK, 0);
    send_block(2'b01, DATA0, 0);
    idle(2);
    send_block(2'b10, IDLE_BLK, 3);
    idle(3);
    drive(1'b1, 2'b01, 32'h11111111);
    do_reset();
    idle(2);
    send_block(2'b10, IDLE_BLK, 0);
    idle(1);
    send_block(2'b10, START0, 0);
    do_reset();
    send_block(2'b01, DATA0, 0);
    idle(5);
    check("queue_drained", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xgmii_decoder.md
XGMII_DECODER -- requirements
Module: xgmii_decoder

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, XGMII/encoded word width; CTRL_WIDTH, default DATA_WIDTH/8, XGMII control bits; HDR_WIDTH, default 2, sync header width.
REQ-002 SHALL have port: i_clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port: i_reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: i_encoded_data  input  DATA_WIDTH  descrambled 64b/66b block half; first half = block bits [31:0], second half = [63:32].
REQ-005 SHALL have port: i_encoded_data_valid  input  1  i_encoded_data/i_sync_hdr qualifier.
REQ-006 SHALL have port: i_sync_hdr  input  HDR_WIDTH  sync header, sampled only with the first half.
REQ-007 SHALL have port: o_xgmii_rxd  output  DATA_WIDTH  XGMII data, lanes 0-3 or 4-7.
REQ-008 SHALL have port: o_xgmii_rxc  output  CTRL_WIDTH  XGMII control, bit n for byte n.
REQ-009 SHALL have port: o_xgmii_valid  output  1  output word qualifier.
REQ-010 SHALL have port: o_decoding_err  output  1  current block replaced by error.

Function
REQ-011 SHALL track block half with a 1-bit counter: starts 0 (first half), toggles per accepted valid word; gaps hold the counter.
REQ-012 SHALL treat block = {second, first}, B[7:0] = block type when sync=2'b10.
REQ-013 Sync 2'b01 SHALL decode as 8 data lanes, rxc=0.
REQ-014 Types SHALL decode: 0x1E all control; 0x78 lane0=FB, lanes1-7=B[63:8]; 0x33 lanes0-3 control from B[35:8], lane4=FB, lanes5-7=B[63:40]; 0x87/99/AA/B4/CC/D2/E1/FF terminate at lane n=0..7, data lanes 0..n-1 from B[8+:8n], lane n=FD, lanes >n=07 with rxc=1.
REQ-015 7-bit control codes at B[8+7k+:7] SHALL map 00->07, 06->06, 1E->FE, 2D->1C, 33->3C, 4B->7C, 55->BC, 66->DC, 78->F7; any other -> FE with error.
REQ-016 Sync 2'b00/2'b11, ordered-set types (0x2D/4B/55/66), or unknown type SHALL produce error block: all lanes FE, rxc=all 1s, o_decoding_err=1.
REQ-017 SHALL run a frame FSM, states RX_C (between frames) and RX_D (in frame); RX_C+start -> RX_D; RX_D+data -> RX_D; RX_D+terminate -> RX_C; RX_C+control -> RX_C.
REQ-018 Sequence violations SHALL replace the block with the error block: RX_C+data or terminate (stay RX_C); RX_D+control (-> RX_C); RX_D+start (flag, stay RX_D).
REQ-019 Latency SHALL be fixed: lanes 0-3 emitted the cycle after the second half is accepted, lanes 4-7 the next cycle, regardless of input valid.
REQ-020 o_xgmii_valid SHALL be 1 exactly in those two cycles; back-to-back input SHALL give continuous output with no overlap.
REQ-021 o_decoding_err SHALL be asserted with both output words of an errored block.

Reset
REQ-022 On reset, outputs SHALL be rxd=0, rxc=0, valid=0, err=0, FSM RX_C, half counter 0.
REQ-023 Reset mid-block or mid-output SHALL discard the partial block and in-flight lanes; decoding SHALL restart with the next valid word as the first half.

Structure
REQ-024 A shared package xgmii_pkg SHALL hold XGMII character constants, 7-bit control codes, block type constants, the rx FSM state enum and a control-code lookup function; xgmii_encoder SHALL use the same package.
REQ-025 No sub-module; decode and FSM in one module.

Verification
REQ-026 Idle block: sync 10, words 0x0000001E, 0x00000000 -> two words 0x07070707, rxc 4'hF, err 0, FSM RX_C.
REQ-027 Start lane0, then data, then term lane 5: sync 10 {0x33221178}; sync 01 data; sync 10 0xD2 -> FB+data, data, T at lane 5, lanes 6-7=07; FSM RX_C->RX_D->RX_C.
REQ-028 Sync 2'b11 during frame -> both words 0xFEFEFEFE, rxc 4'hF, err 1 for 2 cycles, FSM RX_C.
REQ-029 Data block (sync 01) in RX_C -> error block, err 1; following start block decodes normally.
REQ-030 Input gap of 3 cycles between halves -> output exactly 1 and 2 cycles after second half; then reset asserted after first half -> next word treated as first half, no spurious valid.
